// File: rtl/alarm_pio_pkg.sv
// Shared register offsets and edge-type encodings for the button input PIO.
// No logic: constants only.
// No flow control.
package alarm_pio_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // EDGE_TYPE parameter encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchronizer, stability counter and debounced flop.
// Latency: debounced output follows a clean input change after 2 + DEBOUNCE_CYCLES clocks.
// No backpressure: samples every clock.
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_raw,
  output logic deb_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  // The first differing sample is counted by the reset-to-0 cycle, so the
  // DEBOUNCE_CYCLES-th consecutive sample is seen while the counter holds N-2.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          prev_q, prev_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchronizer pipeline and stability counter; the debounced bit flips only
  // after a full run of identical samples that differ from it.
  always_comb begin
    meta_d = in_raw;
    sync_d = meta_q;
    prev_d = sync_q;
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    if ((sync_q == deb_q) || (sync_q != prev_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = sync_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb_out = deb_q;

endmodule

// File: rtl/alarm_button_pio.sv
// Avalon-MM input PIO for front-panel buttons: debounce, sticky edge capture, maskable level irq.
// Latency: capture 1 clock after debounced edge; irq 1 clock after capture/mask change; reads zero-wait.
// No backpressure: slave always accepts, readdata is combinational from address.
module alarm_button_pio
  import alarm_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] w1c;
  logic             wr_en;

  logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .in_raw (in_port[i]),
      .deb_out(deb[i])
    );
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign wr_en = chipselect && !write_n;

  // One-cycle detect pulse from the debounced value and its delayed copy.
  always_comb begin
    detect = deb & ~deb_dly_q;
    case (EDGE_TYPE)
      EDGE_FALL: detect = ~deb & deb_dly_q;
      EDGE_ANY:  detect = deb ^ deb_dly_q;
      default:   detect = deb & ~deb_dly_q;
    endcase
  end

  // Register next-state: W1C clear is applied before the set so a coincident edge wins.
  always_comb begin
    w1c       = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    deb_dly_d = deb;
    edge_d    = (edge_q & ~w1c) | detect;
    mask_d    = (wr_en && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
    irq_d     = |(edge_q & mask_q);
  end

  // Control/status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_dly_q <= '0;
      edge_q    <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      deb_dly_q <= deb_dly_d;
      edge_q    <= edge_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
    end
  end

  // Zero-wait read mux; unused upper bits and the reserved word read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = deb;
      ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_q;
      default:   readdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule
